pio_sm_sequencer: RTL and testbench
===================================

# pio_sm_sequencer

Per-state-machine execution sequencer for the PIO core. It decides on which cycles the state machine's program counter may advance: it applies the fractional-free clock divider, the per-instruction delay field, execution stalls, taken jumps and restarts. It sits between instruction decode/execute and `program_counter`, and drives that block's `pc_en`, `jump_en` and `jump` inputs.

## Interface
Parameters:
- `DIV_W`, 8: width of the clock-divider value.
- `ADDR_W`, 5: instruction address width. Must match the program counter.

Ports:
- `clk`  in  1  single system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `sm_en`  in  1  state machine enable. When low, all counters and state freeze.
- `clkdiv`  in  DIV_W  divider value. 0 and 1 both mean a tick every enabled cycle.
- `instr`  in  16  instruction currently addressed by the PC; `instr[12:8]` is the delay field.
- `stall`  in  1  execute unit cannot complete this instruction (wait unmet, FIFO full/empty).
- `jump_req`  in  1  executed instruction is a taken jump.
- `jump_addr`  in  ADDR_W  jump target.
- `restart`  in  1  single-cycle pulse: abort delay, clear divider, jump to `restart_addr`.
- `restart_addr`  in  ADDR_W  restart target, normally wrap_top.
- `exec_valid`  out  1  instruction is being executed this cycle.
- `pc_en`  out  1  to program_counter.
- `jump_en`  out  1  to program_counter.
- `jump`  out  ADDR_W  to program_counter.
- `delay_active`  out  1  state machine is in a delay phase.

## Operation
Divider:
- `div_cnt` (DIV_W) is 0 after reset.
- `tick = sm_en && div_cnt == 0`.
- On a tick, `div_cnt` loads `max(clkdiv,1) - 1`. Otherwise, when `sm_en` is high, it decrements. When `sm_en` is low, it holds.
- A new `clkdiv` value takes effect at the next reload.

States, in a registered FSM: `EXEC`, `DELAY`. Reset state is `EXEC` with `dly_cnt = 0`.

On a tick in `EXEC`:
- `exec_valid = 1`.
- If `stall` is high: `pc_en = 0` and the FSM stays in `EXEC`. The same instruction retries on the next tick. `jump_req` is ignored.
- Otherwise: `pc_en = 1`, `jump_en = jump_req`, `jump = jump_addr`.
  - If `instr[12:8] != 0`: `dly_cnt <= instr[12:8]`, go to `DELAY`.
  - Else stay in `EXEC`.

On a tick in `DELAY`:
- `dly_cnt` decrements.
- When `dly_cnt == 1` on that tick, go to `EXEC`. A delay of N therefore consumes exactly N ticks.
- `exec_valid` and `pc_en` stay 0.
- `delay_active = (state == DELAY)`.

`restart` has priority over everything, including `sm_en = 0`:
- That cycle: `pc_en = 1`, `jump_en = 1`, `jump = restart_addr`, `exec_valid = 0`.
- Next state: `EXEC`, `dly_cnt = 0`, `div_cnt = 0`.
- So if `sm_en` is high, the first instruction at `restart_addr` executes on the following cycle.

Outputs are Mealy (combinational from state and inputs). With no tick and no restart, `pc_en`, `jump_en` and `exec_valid` are all 0.

`jump` is 0 whenever `jump_en` is 0, so waveforms stay clean.

Reset value of every output: 0 (`delay_active` is 0 because the reset state is `EXEC`).

Reset asserted mid-delay or mid-divide discards all progress.

## Timing
- `pc_en` / `jump_en` are asserted in the execute cycle. The PC changes at the following edge, so the next instruction is visible one cycle later.
- `instr` must be valid combinationally for the current PC in the same cycle. The block adds no fetch latency.
- Issue rate is one instruction per `max(clkdiv,1)` enabled cycles, plus `delay * max(clkdiv,1)` cycles, plus stalled ticks.
- Deasserting `sm_en` freezes everything exactly. Reasserting it resumes with the same `div_cnt`, `dly_cnt` and state.

## Structure
- `pio_pkg` holds:
  - the `sm_state_t` enum (`EXEC`, `DELAY`);
  - constants `DELAY_MSB = 12` and `DELAY_LSB = 8`;
  - the default `ADDR_W`.
- One sub-module, `pio_clk_div`, with ports `clk`, `rst_n`, `en`, `clear`, `clkdiv` → `tick`. It is reused by other timed PIO logic.
- The FSM and output logic stay in `pio_sm_sequencer`.

## Test plan
- **Divider:** reset, `sm_en = 1`, `clkdiv = 3`, `instr = 0`, no stall → `exec_valid` / `pc_en` pulse on enabled cycles 0, 3, 6, 9. With `clkdiv = 0` → a pulse every cycle.
- **Delay:** `clkdiv = 1`, `instr[12:8] = 3` → `pc_en` in cycle 0, `delay_active` in cycles 1–3, next `exec_valid` in cycle 4. With `clkdiv = 2` → next exec in cycle 8.
- **Stall:** `stall` high for 2 ticks with `jump_req = 1` → `pc_en = 0` on both. On the third tick with `stall = 0` → `pc_en = 1`, `jump_en = 1`, `jump = jump_addr`. Delay starts only after that completion.
- **Restart during delay:** `instr` delay 31, `restart` pulsed in delay cycle 5 with `restart_addr = 5'd4` → that cycle `jump_en = 1`, `jump = 4`; next cycle `exec_valid = 1`, `delay_active = 0`.
- **Freeze:** `sm_en` dropped for 10 cycles mid-delay and mid-divide → no outputs. After re-enable, the remaining delay ticks and divider phase match an uninterrupted run.
- **Reset:** async `rst_n` low mid-delay with `clk` stopped → all outputs go to 0 immediately. After release, the first enabled cycle is a tick in `EXEC`.

Source files
------------

// File: rtl/pio_pkg.sv
// Shared types and constants for the PIO state-machine datapath.
package pio_pkg;

  // Position of the per-instruction delay field inside a 16-bit instruction.
  localparam int DELAY_MSB = 12;
  localparam int DELAY_LSB = 8;
  localparam int DELAY_W   = DELAY_MSB - DELAY_LSB + 1;

  // Default instruction address width (must match program_counter).
  localparam int DEFAULT_ADDR_W = 5;

  // Sequencer phase: executing an instruction, or burning its delay ticks.
  typedef enum logic {
    EXEC  = 1'b0,
    DELAY = 1'b1
  } sm_state_t;

endpackage : pio_pkg

// File: rtl/pio_clk_div.sv
// Integer clock divider: emits one enabled-cycle tick every max(clkdiv,1)
// enabled cycles. A new clkdiv is only picked up when the counter reloads.
module pio_clk_div #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clear,
  input  logic [DIV_W-1:0] clkdiv,
  output logic             tick
);

  logic [DIV_W-1:0] div_cnt;

  // A tick fires on any enabled cycle where the countdown has reached zero.
  assign tick = en && (div_cnt == '0);

  // Countdown register: clear wins, then reload on tick, decrement when enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (clear) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values, independent of block evaluation order.
      div_cnt <= '0;
    end else if (en) begin
      if (div_cnt == '0) begin
        // 0 and 1 both mean "every cycle", so both reload to zero.
        div_cnt <= (clkdiv == '0) ? '0 : clkdiv - DIV_W'(1);
      end else begin
        div_cnt <= div_cnt - DIV_W'(1);
      end
    end
  end

endmodule : pio_clk_div

// File: rtl/pio_sm_sequencer.sv
// Per-state-machine execution sequencer: decides when the PC may advance,
// applying the clock divider, instruction delays, stalls, jumps and restarts.
module pio_sm_sequencer
  import pio_pkg::*;
#(
  parameter int DIV_W  = 8,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sm_en,
  input  logic [DIV_W-1:0]  clkdiv,
  input  logic [15:0]       instr,
  input  logic              stall,
  input  logic              jump_req,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic              restart,
  input  logic [ADDR_W-1:0] restart_addr,
  output logic              exec_valid,
  output logic              pc_en,
  output logic              jump_en,
  output logic [ADDR_W-1:0] jump,
  output logic              delay_active
);

  sm_state_t          state, state_nxt;
  logic [DELAY_W-1:0] dly_cnt, dly_cnt_nxt;
  logic [DELAY_W-1:0] instr_delay;
  logic               tick;

  assign instr_delay = instr[DELAY_MSB:DELAY_LSB];

  // Only the delay field matters here; opcode/operand bits belong to execute.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr[15:DELAY_MSB+1], instr[DELAY_LSB-1:0]};

  // Restart clears the divider so the restart target executes next cycle.
  pio_clk_div #(
    .DIV_W (DIV_W)
  ) u_clk_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (sm_en),
    .clear  (restart),
    .clkdiv (clkdiv),
    .tick   (tick)
  );

  // State and delay-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= EXEC;
      dly_cnt <= '0;
    end else begin
      state   <= state_nxt;
      dly_cnt <= dly_cnt_nxt;
    end
  end

  assign delay_active = (state == DELAY);

  // Next-state and Mealy outputs; restart overrides ticks and sm_en.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the block leaves one unassigned and infers a latch.
    state_nxt   = state;
    dly_cnt_nxt = dly_cnt;
    exec_valid  = 1'b0;
    pc_en       = 1'b0;
    jump_en     = 1'b0;
    jump        = '0;

    if (restart) begin
      pc_en       = 1'b1;
      jump_en     = 1'b1;
      jump        = restart_addr;
      state_nxt   = EXEC;
      dly_cnt_nxt = '0;
    end else if (tick) begin
      unique case (state)
        EXEC: begin
          exec_valid = 1'b1;
          // A stalled instruction simply retries on the next tick.
          if (!stall) begin
            pc_en   = 1'b1;
            jump_en = jump_req;
            jump    = jump_req ? jump_addr : '0;
            if (instr_delay != '0) begin
              dly_cnt_nxt = instr_delay;
              state_nxt   = DELAY;
            end
          end
        end
        DELAY: begin
          dly_cnt_nxt = dly_cnt - DELAY_W'(1);
          // Leaving on the tick that sees 1 makes a delay of N cost N ticks.
          if (dly_cnt <= DELAY_W'(1)) begin
            state_nxt = EXEC;
          end
        end
        default: begin
          state_nxt = EXEC;
        end
      endcase
    end
  end

endmodule : pio_sm_sequencer

// File: tb/tb_pio_sm_sequencer.sv
// Scoreboard bench for pio_sm_sequencer: a driver applies directed and random
// stimulus and queues expected outputs from an abstract model; a monitor on
// the falling edge pops and compares.
module tb_pio_sm_sequencer;

  localparam int DIV_W  = 8;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              sm_en;
  logic [DIV_W-1:0]  clkdiv;
  logic [15:0]       instr;
  logic              stall;
  logic              jump_req;
  logic [ADDR_W-1:0] jump_addr;
  logic              restart;
  logic [ADDR_W-1:0] restart_addr;
  logic              exec_valid;
  logic              pc_en;
  logic              jump_en;
  logic [ADDR_W-1:0] jump;
  logic              delay_active;

  logic clk_run = 1'b1;
  always #5 if (clk_run) clk = ~clk;

  pio_sm_sequencer #(
    .DIV_W  (DIV_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sm_en        (sm_en),
    .clkdiv       (clkdiv),
    .instr        (instr),
    .stall        (stall),
    .jump_req     (jump_req),
    .jump_addr    (jump_addr),
    .restart      (restart),
    .restart_addr (restart_addr),
    .exec_valid   (exec_valid),
    .pc_en        (pc_en),
    .jump_en      (jump_en),
    .jump         (jump),
    .delay_active (delay_active)
  );

  typedef struct packed {
    logic              exec_valid;
    logic              pc_en;
    logic              jump_en;
    logic [ADDR_W-1:0] jump;
    logic              delay_active;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: enabled cycles left until the next tick, and delay ticks
  // still owed by the last completed instruction.
  int m_wait  = 0;
  int m_delay = 0;

  task automatic model_step(output exp_t e);
    bit tick;
    int period;
    e = '0;
    tick   = sm_en && (m_wait == 0);
    period = (clkdiv == 0) ? 1 : int'(clkdiv);
    e.delay_active = (m_delay > 0);
    if (restart) begin
      e.pc_en   = 1'b1;
      e.jump_en = 1'b1;
      e.jump    = restart_addr;
      m_wait    = 0;
      m_delay   = 0;
    end else begin
      if (tick) begin
        if (m_delay > 0) begin
          m_delay = m_delay - 1;
        end else begin
          e.exec_valid = 1'b1;
          if (!stall) begin
            e.pc_en   = 1'b1;
            e.jump_en = jump_req;
            e.jump    = jump_req ? jump_addr : '0;
            m_delay   = int'(instr[12:8]);
          end
        end
        m_wait = period - 1;
      end else if (sm_en) begin
        m_wait = m_wait - 1;
      end
    end
  endtask

  // Apply one cycle of inputs just after the rising edge and queue the
  // outputs expected for that cycle.
  task automatic drive(input bit en, input int div, input int dly,
                       input bit stl, input bit jr, input int ja,
                       input bit rs, input int ra);
    exp_t e;
    @(posedge clk);
    #1;
    sm_en        = en;
    clkdiv       = DIV_W'(div);
    instr        = 16'(($urandom & 16'hE0FF) | ((dly & 31) << 8));
    stall        = stl;
    jump_req     = jr;
    jump_addr    = ADDR_W'(ja);
    restart      = rs;
    restart_addr = ADDR_W'(ra);
    model_step(e);
    exp_q.push_back(e);
  endtask

  // Monitor: compare the DUT's Mealy outputs mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("exec_valid",   32'(exec_valid),   32'(e.exec_valid));
      check("pc_en",        32'(pc_en),        32'(e.pc_en));
      check("jump_en",      32'(jump_en),      32'(e.jump_en));
      check("jump",         32'(jump),         32'(e.jump));
      check("delay_active", 32'(delay_active), 32'(e.delay_active));
    end
  end

  task automatic idle_inputs();
    sm_en = 0; clkdiv = 0; instr = 0; stall = 0; jump_req = 0;
    jump_addr = 0; restart = 0; restart_addr = 0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_exec_valid"},   32'(exec_valid),   32'd0);
    check({tag, "_pc_en"},        32'(pc_en),        32'd0);
    check({tag, "_jump_en"},      32'(jump_en),      32'd0);
    check({tag, "_jump"},         32'(jump),         32'd0);
    check({tag, "_delay_active"}, 32'(delay_active), 32'd0);
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    #1;
    check_zero_outputs("reset");
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // Divider: clkdiv=3 then clkdiv=0.
    repeat (12) drive(1, 3, 0, 0, 0, 0, 0, 0);
    repeat (4)  drive(1, 0, 0, 0, 0, 0, 0, 0);

    // Delay of 3 at clkdiv=1, then at clkdiv=2.
    drive(1, 1, 3, 0, 0, 0, 0, 0);
    repeat (5) drive(1, 1, 0, 0, 0, 0, 0, 0);
    drive(1, 2, 3, 0, 0, 0, 0, 0);
    repeat (10) drive(1, 2, 0, 0, 0, 0, 0, 0);

    // Stall two ticks with a pending jump, then complete with a delay.
    repeat (2) drive(1, 1, 2, 1, 1, 9, 0, 0);
    drive(1, 1, 2, 0, 1, 9, 0, 0);
    repeat (4) drive(1, 1, 0, 0, 0, 0, 0, 0);

    // Restart in the fifth delay cycle of a 31-tick delay.
    drive(1, 1, 31, 0, 0, 0, 0, 0);
    repeat (4) drive(1, 1, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0, 1, 4);
    repeat (3) drive(1, 1, 0, 0, 0, 0, 0, 0);

    // Freeze mid-delay and mid-divide, then resume; restart while frozen.
    drive(1, 3, 2, 0, 0, 0, 0, 0);
    repeat (4)  drive(1, 3, 0, 0, 0, 0, 0, 0);
    repeat (10) drive(0, 3, 0, 0, 0, 0, 0, 0);
    repeat (8)  drive(1, 3, 0, 0, 0, 0, 0, 0);
    drive(0, 3, 0, 0, 0, 0, 1, 17);
    repeat (6) drive(1, 3, 0, 0, 0, 0, 0, 0);

    // Async reset mid-delay with the clock stopped.
    drive(1, 2, 20, 0, 0, 0, 0, 0);
    repeat (5) drive(1, 2, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1 clk_run = 1'b0;
    #2;
    sm_en = 1'b0;
    restart = 1'b0;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("async_reset");
    m_wait  = 0;
    m_delay = 0;
    #3 rst_n = 1'b1;
    #1 clk_run = 1'b1;
    repeat (6) drive(1, 2, 0, 0, 0, 0, 0, 0);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      int dly;
      dly = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 31))
                                        : int'($urandom_range(0, 2)) * int'($urandom_range(0, 1));
      drive($urandom_range(0, 9) != 0,
            ($urandom_range(0, 15) == 0) ? int'($urandom_range(5, 12)) : int'($urandom_range(0, 4)),
            dly,
            $urandom_range(0, 4) == 0,
            $urandom_range(0, 2) == 0,
            int'($urandom_range(0, 31)),
            $urandom_range(0, 40) == 0,
            int'($urandom_range(0, 31)));
    end

    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_pio_sm_sequencer
